// File: rtl/pixel_frame_sink.sv
// pixel_frame_sink: receiving end of the resolved-pixel stream.
// Buffers raster-order pixels in a small FIFO, tags each with (x,y)
// and a last flag, and drains them over valid/ready. Pulses
// frame_done when the final pixel of a frame leaves the block.
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   start           arms a new frame from IDLE or DONE
//   in_valid/ready  upstream handshake, in_color = {r,g,b}
//   out_valid/ready downstream handshake
//   out_color/x/y   head-of-FIFO pixel and its raster coordinate
//   out_last        head pixel is the final pixel of the frame
//   busy            frame in progress (COLLECT or DRAIN)
//   frame_done      one-cycle pulse after the last pixel is popped
module pixel_frame_sink #(
    parameter int PIXEL_WIDTH  = 16,
    parameter int PIXEL_HEIGHT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int XW           = $clog2(PIXEL_WIDTH),
    parameter int YW           = $clog2(PIXEL_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [23:0]   in_color,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   out_color,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_last,
    output logic          busy,
    output logic          frame_done
);

    localparam int TOTAL = PIXEL_WIDTH * PIXEL_HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    // Entry layout, msb to lsb: {color, x, y, last}
    localparam int EW    = 24 + XW + YW + 1;
    localparam int Y_LO  = 1;
    localparam int X_LO  = Y_LO + YW;
    localparam int C_LO  = X_LO + XW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          frame_done_q, frame_done_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          x_last;
    logic          y_last;
    logic          pix_last;
    logic          idx_last;
    logic [EW-1:0] head;
    logic [EW-1:0] push_entry;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Depends on registered state only, never on out_ready
    assign in_ready  = (state_q == S_COLLECT) && !fifo_full;
    assign out_valid = !fifo_empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign x_last   = (x_q == XW'(PIXEL_WIDTH - 1));
    assign y_last   = (y_q == YW'(PIXEL_HEIGHT - 1));
    assign pix_last = x_last && y_last;
    assign idx_last = (cnt_q == CW'(TOTAL - 1));

    assign push_entry = {in_color, x_q, y_q, pix_last};
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // Head fields are forced to zero while the FIFO is empty so stale
    // storage never shows on the outputs.
    assign out_color = out_valid ? head[C_LO +: 24] : '0;
    assign out_x     = out_valid ? head[X_LO +: XW] : '0;
    assign out_y     = out_valid ? head[Y_LO +: YW] : '0;
    assign out_last  = out_valid & head[0];

    assign busy       = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        frame_done_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                if (push) begin
                    cnt_d = cnt_q + CW'(1);
                    if (x_last) begin
                        x_d = '0;
                        y_d = y_last ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (idx_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Pulse is registered so it lands the cycle after the pop
                if (pop && head[0]) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: it is only visible through a valid head
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

endmodule
